// File: rtl/pipe_mux_nx1.sv
// N-to-1 registered multiplexer with valid/ready handshakes on every channel.
// Channel choice is either a fixed select (MODE=0) or round-robin over valid inputs (MODE=1).
module pipe_mux_nx1 #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_chan
);

  logic [WIDTH-1:0] chan_data [N];
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  chan_q, chan_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             ld;
  logic             xfer_in;
  logic             sel_ok;
  logic             rr_ok;
  logic             grant_ok;
  logic [SELW-1:0]  rr_grant;
  logic [SELW-1:0]  grant;
  logic [WIDTH-1:0] grant_data;

  assign ld = !valid_q || out_ready;

  // Ready never looks at the granted channel's own valid in fixed-select mode.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi]  = rst_n && ld && grant_ok && (grant == SELW'(gi));
    end
  endgenerate

  assign sel_ok = int'(sel) < N;

  // Scan from the farthest candidate down so the nearest one after ptr wins.
  always_comb begin
    rr_grant = '0;
    rr_ok    = 1'b0;
    for (int s = N; s >= 1; s--) begin
      if (in_valid[(int'(ptr_q) + s) % N]) begin
        rr_grant = SELW'((int'(ptr_q) + s) % N);
        rr_ok    = 1'b1;
      end
    end
  end

  assign grant    = (MODE == 0) ? sel    : rr_grant;
  assign grant_ok = (MODE == 0) ? sel_ok : rr_ok;

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant == SELW'(k)) begin
        grant_data = chan_data[k];
      end
    end
  end

  assign xfer_in = |(in_valid & in_ready);

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    if (xfer_in) begin
      data_d  = grant_data;
      valid_d = 1'b1;
      chan_d  = grant;
      ptr_d   = grant;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // ptr resets to N-1 so channel 0 is searched first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
      ptr_q   <= SELW'(N - 1);
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_chan  = chan_q;

endmodule

// File: tb/tb_pipe_mux_nx1.sv
// Bench for pipe_mux_nx1: three instances (fixed N=2, fixed N=4 with wide sel, round-robin N=4)
// checked every cycle against a transfer-level reference model, plus directed scenarios.
module tb_pipe_mux_nx1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Stimulus per instance: 0 = MODE0/N2, 1 = MODE0/N4/SELW3, 2 = MODE1/N4
  logic [31:0] dat [3][4];
  logic [3:0]  vld [3];
  int          selv [3];
  logic        ordy [3];

  int mn    [3] = '{2, 4, 4};
  int mmode [3] = '{0, 0, 1};

  // Reference model state
  bit          mv [3];
  logic [31:0] md [3];
  int          mc [3];
  int          mp [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [63:0]  in_data0;
  logic [127:0] in_data1, in_data2;
  logic [1:0]   in_ready0;
  logic [3:0]   in_ready1, in_ready2;
  logic [31:0]  out_data0, out_data1, out_data2;
  logic         out_valid0, out_valid1, out_valid2;
  logic [0:0]   out_chan0;
  logic [2:0]   out_chan1;
  logic [1:0]   out_chan2;
  logic [0:0]   sel0;
  logic [2:0]   sel1;
  logic [1:0]   sel2;

  assign in_data0 = {dat[0][1], dat[0][0]};
  assign in_data1 = {dat[1][3], dat[1][2], dat[1][1], dat[1][0]};
  assign in_data2 = {dat[2][3], dat[2][2], dat[2][1], dat[2][0]};
  assign sel0 = 1'(selv[0]);
  assign sel1 = 3'(selv[1]);
  assign sel2 = 2'(selv[2]);

  pipe_mux_nx1 #(.WIDTH(32), .N(2), .SELW(1), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(vld[0][1:0]),
    .in_ready(in_ready0), .sel(sel0), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(ordy[0]), .out_chan(out_chan0));

  pipe_mux_nx1 #(.WIDTH(32), .N(4), .SELW(3), .MODE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(vld[1]),
    .in_ready(in_ready1), .sel(sel1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(ordy[1]), .out_chan(out_chan1));

  pipe_mux_nx1 #(.WIDTH(32), .N(4), .SELW(2), .MODE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(vld[2]),
    .in_ready(in_ready2), .sel(sel2), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(ordy[2]), .out_chan(out_chan2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Grant by the rules: fixed select, or first valid channel after the last one served.
  task automatic exp_grant(input int i, output int g, output bit ok);
    g  = 0;
    ok = 1'b0;
    if (mmode[i] == 0) begin
      g  = selv[i];
      ok = (selv[i] < mn[i]);
    end else begin
      for (int s = 1; s <= mn[i]; s++) begin
        if (!ok && vld[i][(mp[i] + s) % mn[i]]) begin
          g  = (mp[i] + s) % mn[i];
          ok = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [3:0] dut_rdy(input int i);
    case (i)
      0:       return {2'b00, in_ready0};
      1:       return in_ready1;
      default: return in_ready2;
    endcase
  endfunction

  function automatic logic [31:0] dut_data(input int i);
    case (i)
      0:       return out_data0;
      1:       return out_data1;
      default: return out_data2;
    endcase
  endfunction

  function automatic logic dut_valid(input int i);
    case (i)
      0:       return out_valid0;
      1:       return out_valid1;
      default: return out_valid2;
    endcase
  endfunction

  function automatic int dut_chan(input int i);
    case (i)
      0:       return int'(out_chan0);
      1:       return int'(out_chan1);
      default: return int'(out_chan2);
    endcase
  endfunction

  // One clock: check readies, clock, advance the model, check the registered outputs.
  task automatic tick();
    int         g [3];
    bit         ok;
    logic [3:0] er [3];
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_grant(i, g[i], ok);
      er[i] = (rst_n && (!mv[i] || ordy[i]) && ok) ? (4'b0001 << g[i]) : 4'b0000;
      chk($sformatf("in_ready%0d", i), {28'b0, dut_rdy(i)}, {28'b0, er[i]});
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        mv[i] = 1'b0; md[i] = '0; mc[i] = 0; mp[i] = mn[i] - 1;
      end else if ((er[i] & vld[i]) != 4'b0000) begin
        mv[i] = 1'b1; md[i] = dat[i][g[i]]; mc[i] = g[i]; mp[i] = g[i];
      end else if (mv[i] && ordy[i]) begin
        mv[i] = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("out_valid%0d", i), {31'b0, dut_valid(i)}, {31'b0, mv[i]});
      chk($sformatf("out_data%0d", i), dut_data(i), md[i]);
      chk($sformatf("out_chan%0d", i), dut_chan(i), mc[i]);
    end
    $display("cyc=%0d rst_n=%0b u0:v=%0b d=%h c=%0d u1:v=%0b d=%h c=%0d u2:v=%0b d=%h c=%0d",
             cyc, rst_n, out_valid0, out_data0, out_chan0, out_valid1, out_data1, out_chan1,
             out_valid2, out_data2, out_chan2);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) dat[i][k] = '0;
      vld[i] = '0; selv[i] = 0; ordy[i] = 1'b1;
      mv[i] = 1'b0; md[i] = '0; mc[i] = 0; mp[i] = mn[i] - 1;
    end
    // Data presented during reset must be lost.
    vld[2] = 4'b1111; dat[2][0] = 32'h5555_0000;
    tick();
    tick();

    // Fixed select N=2 with sel switching, and round-robin with all channels valid.
    rst_n = 1'b1;
    dat[0][0] = 32'h0F0F_0F0F; dat[0][1] = 32'hF0F0_F0F0; vld[0] = 4'b0011;
    for (int k = 0; k < 4; k++) dat[2][k] = 32'hA000_0000 + k;
    vld[2] = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) selv[0] = 1;
      tick();
      chk("rr_seq_chan", dut_chan(2), c % 4);
      chk("fix_data", out_data0, (c < 5) ? 32'h0F0F_0F0F : 32'hF0F0_F0F0);
    end
    chk("fix_chan_after_sel", {31'b0, out_chan0}, 32'd1);

    // Out-of-range select: nothing is ever accepted.
    selv[1] = 5; vld[1] = 4'b1111;
    for (int k = 0; k < 4; k++) dat[1][k] = $urandom;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("sel_oob_rdy", {28'b0, in_ready1}, 32'd0);
      chk("sel_oob_valid", {31'b0, out_valid1}, 32'd0);
    end

    // Round-robin skips invalid channels.
    vld[2] = 4'b0100;
    tick(); chk("rr_only2", dut_chan(2), 2);
    vld[2] = 4'b0101;
    tick(); chk("rr_02_a", dut_chan(2), 0);
    tick(); chk("rr_02_b", dut_chan(2), 2);
    tick(); chk("rr_02_c", dut_chan(2), 0);

    // Backpressure holds the word and blocks all inputs.
    selv[1] = 0; vld[1] = 4'b0001; dat[1][0] = 32'hDEAD_BEEF;
    tick();
    ordy[1] = 1'b0; dat[1][0] = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_data", out_data1, 32'hDEAD_BEEF);
      chk("bp_valid", {31'b0, out_valid1}, 32'd1);
      chk("bp_rdy", {28'b0, in_ready1}, 32'd0);
    end
    ordy[1] = 1'b1;
    tick();
    chk("bp_release", out_data1, 32'h1234_5678);

    // Reset mid-stream while stalled.
    vld[2] = 4'b1111; ordy[2] = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_valid", {31'b0, out_valid2}, 32'd0);
    chk("rst_data", out_data2, 32'd0);
    chk("rst_chan", dut_chan(2), 0);
    rst_n = 1'b1; vld[2] = 4'b0110; ordy[2] = 1'b1;
    tick();
    chk("post_rst_grant", dut_chan(2), 1);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 4; k++) dat[i][k] = $urandom;
        vld[i]  = 4'($urandom);
        ordy[i] = ($urandom_range(0, 9) < 7);
      end
      selv[0] = $urandom_range(0, 1);
      selv[1] = $urandom_range(0, 7);
      selv[2] = $urandom_range(0, 3);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
